// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: FETCH -> DECODE -> EXEC -> [MEM] -> WB, external imem/dmem via req/ready.
// Latency with ready tied high: ALU/lui 4 cycles, lw 5, sw 4, branch/jump/halt 3; each wait state adds one.
// Backpressure: requests are held with stable address/data until ready; reset low abandons any request.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ADDR_W      = 32,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic [31:0]       result,
    output logic              retire,
    output logic              halted
);
    localparam logic [ADDR_W-1:0] PC_INIT = RESET_PC[ADDR_W-1:0];

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08, FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25, FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t            r_state, w_next_state;
    logic [ADDR_W-1:0] r_pc, r_pc4;
    logic [31:0]       r_ir, r_a, r_b, r_imm, r_val, r_result;
    logic [4:0]        r_dst;
    logic              r_wen, r_retire, r_halted;
    logic [31:0]       r_regs [32];

    logic [5:0]        w_op, w_funct;
    logic [4:0]        w_rs, w_rt, w_rd, w_shamt;
    logic              w_is_lw, w_is_sw, w_is_halt;
    logic [31:0]       w_alu_val;
    logic              w_alu_ok, w_is_ctl;
    logic [4:0]        w_dst;
    logic [ADDR_W-1:0] w_ctl_pc, w_br_pc, w_j_pc;

    assign w_op      = r_ir[31:26];
    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_shamt   = r_ir[10:6];
    assign w_funct   = r_ir[5:0];
    assign w_is_lw   = (w_op == OP_LW);
    assign w_is_sw   = (w_op == OP_SW);
    assign w_is_halt = (w_op == HALT_OPCODE);

    // Branch target is relative to pc4; jump target keeps the top nibble of pc4, both wrap at ADDR_W.
    assign w_br_pc = r_pc4 + ADDR_W'(r_imm << 2);
    assign w_j_pc  = ADDR_W'((32'(r_pc4) & 32'hF000_0000) | {4'b0000, r_ir[25:0], 2'b00});

    assign imem_req   = reset && (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign dmem_req   = reset && (r_state == S_MEM);
    assign dmem_we    = dmem_req && w_is_sw;
    assign dmem_addr  = {r_val[ADDR_W-1:2], 2'b00};
    assign dmem_wdata = r_b;
    assign result     = r_result;
    assign retire     = r_retire;
    assign halted     = r_halted;

    // EXEC-stage datapath: ALU result, destination and control-transfer target.
    always_comb begin
        w_alu_val = 32'h0;
        w_alu_ok  = 1'b0;
        w_dst     = w_rt;
        w_is_ctl  = 1'b0;
        w_ctl_pc  = r_pc4;
        case (w_op)
            OP_RTYPE: begin
                w_dst    = w_rd;
                w_alu_ok = 1'b1;
                case (w_funct)
                    FN_SLL:  w_alu_val = r_b << w_shamt;
                    FN_SRL:  w_alu_val = r_b >> w_shamt;
                    FN_ADD:  w_alu_val = r_a + r_b;
                    FN_SUB:  w_alu_val = r_a - r_b;
                    FN_AND:  w_alu_val = r_a & r_b;
                    FN_OR:   w_alu_val = r_a | r_b;
                    FN_NOR:  w_alu_val = ~(r_a | r_b);
                    FN_SLT:  w_alu_val = ($signed(r_a) < $signed(r_b)) ? 32'h1 : 32'h0;
                    FN_JR: begin
                        w_alu_ok = 1'b0;
                        w_is_ctl = 1'b1;
                        w_ctl_pc = ADDR_W'(r_a);
                    end
                    default: w_alu_ok = 1'b0;
                endcase
            end
            OP_J, OP_JAL: begin
                w_is_ctl = 1'b1;
                w_ctl_pc = w_j_pc;
            end
            OP_BEQ: begin
                w_is_ctl = 1'b1;
                w_ctl_pc = (r_a == r_b) ? w_br_pc : r_pc4;
            end
            OP_BNE: begin
                w_is_ctl = 1'b1;
                w_ctl_pc = (r_a != r_b) ? w_br_pc : r_pc4;
            end
            OP_ADDI: begin w_alu_val = r_a + r_imm;             w_alu_ok = 1'b1; end
            OP_ANDI: begin w_alu_val = r_a & r_imm;             w_alu_ok = 1'b1; end
            OP_ORI:  begin w_alu_val = r_a | r_imm;             w_alu_ok = 1'b1; end
            OP_LUI:  begin w_alu_val = {r_imm[15:0], 16'h0000}; w_alu_ok = 1'b1; end
            OP_LW, OP_SW: w_alu_val = r_a + r_imm;
            default: ;
        endcase
    end

    // Next-state sequencing; memory states wait for their ready.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:  if (imem_ready) w_next_state = S_DECODE;
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC: begin
                if (w_is_halt)                 w_next_state = S_HALT;
                else if (w_is_ctl)             w_next_state = S_FETCH;
                else if (w_is_lw || w_is_sw)   w_next_state = S_MEM;
                else                           w_next_state = S_WB;
            end
            S_MEM:    if (dmem_ready) w_next_state = w_is_lw ? S_WB : S_FETCH;
            S_WB:     w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next_state;
    end

    // Datapath registers, register file and retire bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc     <= PC_INIT;
            r_pc4    <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
            r_val    <= '0;
            r_dst    <= '0;
            r_wen    <= 1'b0;
            r_result <= '0;
            r_retire <= 1'b0;
            r_halted <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_FETCH: if (imem_ready) r_ir <= imem_rdata;
                S_DECODE: begin
                    r_a   <= r_regs[w_rs];
                    r_b   <= r_regs[w_rt];
                    r_imm <= (w_op == OP_ANDI || w_op == OP_ORI) ? {16'h0000, r_ir[15:0]}
                                                                : {{16{r_ir[15]}}, r_ir[15:0]};
                    r_pc4 <= r_pc + ADDR_W'(4);
                end
                S_EXEC: begin
                    if (w_is_halt) begin
                        r_retire <= 1'b1;
                        r_halted <= 1'b1;
                    end else if (w_is_ctl) begin
                        r_pc     <= w_ctl_pc;
                        r_result <= 32'(w_ctl_pc);
                        r_retire <= 1'b1;
                        if (w_op == OP_JAL) r_regs[31] <= 32'(r_pc4);
                    end else begin
                        r_val <= w_alu_val;
                        r_wen <= w_alu_ok;
                        r_dst <= w_dst;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (w_is_sw) begin
                            r_result <= r_b;
                            r_retire <= 1'b1;
                            r_pc     <= r_pc4;
                        end else begin
                            r_val <= dmem_rdata;
                            r_wen <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    // Unsupported encodings arrive here with r_wen clear: nop that still retires.
                    if (r_wen) begin
                        r_result <= r_val;
                        if (r_dst != 5'd0) r_regs[r_dst] <= r_val;
                    end
                    r_pc     <= r_pc4;
                    r_retire <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed programs with imem/dmem models having programmable wait states.
// Expected retire results/latencies, fetch addresses and dmem transactions are queued when a program is loaded.
// A monitor pops and compares them whenever the core presents a retire, fetch or data request.
module tb_mips_multicycle_core;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, result;

    mips_multicycle_core #(.RESET_PC(32'h0), .ADDR_W(32), .HALT_OPCODE(6'h3F)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .result(result), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] res; int gap; } exp_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } dexp_t;

    exp_t        exp_q[$];
    dexp_t       dq[$];
    logic [31:0] fq[$];
    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];
    int          checks = 0, errors = 0;
    int          cyc = 0, last_cyc = 0, n_ret = 0;
    int          iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    bit          chk_fetch = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(int op, int rs, int rt, logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction
    function automatic logic [31:0] enc_j(int op, int target);
        return {6'(op), 26'(target)};
    endfunction
    localparam logic [31:0] HALT = 32'hFC00_0000;

    // Memory models: ready after a programmable number of wait cycles.
    assign imem_ready = imem_req && (icnt == iwait);
    assign imem_rdata = imem[imem_addr[9:2]];
    assign dmem_ready = dmem_req && (dcnt == dwait);
    assign dmem_rdata = dmem[dmem_addr[9:2]];

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
        if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[9:2]] <= dmem_wdata;
    end

    // Monitor: compare retires, fetches and data requests against the queued expectations.
    always @(negedge clk) begin
        if (reset && retire) begin
            n_ret++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL retire_extra actual=%h required=none", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", result, e.res);
                if (e.gap != 0) chk("latency", 32'(cyc - last_cyc), 32'(e.gap));
            end
            last_cyc = cyc;
        end
        if (chk_fetch && imem_req && imem_ready) begin
            if (fq.size() == 0) begin
                checks++; errors++;
                $display("FAIL fetch_extra actual=%h required=none", imem_addr);
            end else chk("fetch_addr", imem_addr, fq.pop_front());
        end
        if (dmem_req) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL dmem_extra actual=%h required=none", dmem_addr);
            end else begin
                chk("dmem_addr", dmem_addr, dq[0].addr);
                chk("dmem_we", 32'(dmem_we), 32'(dq[0].we));
                if (dq[0].we) chk("dmem_wdata", dmem_wdata, dq[0].wdata);
                if (dmem_ready) void'(dq.pop_front());
            end
        end
    end

    task automatic start_reset();
        reset = 1'b0;
        exp_q.delete(); dq.delete(); fq.delete();
        chk_fetch = 0; iwait = 0; dwait = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin imem[i] = 32'h0; dmem[i] = 32'h0; end
    endtask

    task automatic release_reset();
        reset = 1'b1;
        last_cyc = cyc;
        n_ret = 0;
    endtask

    task automatic put(input int addr, input logic [31:0] ins, input logic [31:0] res, input int gap);
        imem[addr >> 2] = ins;
        exp_q.push_back('{res: res, gap: gap});
    endtask

    task automatic run_halt(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (halted) break;
        end
        chk("halt_reached", 32'(halted), 32'h1);
        chk("retires_drained", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic run_ret(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (n_ret >= n) break;
        end
        chk("retire_count", 32'(n_ret), 32'(n));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        // Reset state.
        start_reset();
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_dmem_req", 32'(dmem_req), 32'h0);
        chk("rst_retire", 32'(retire), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);

        // T1: ALU sequence with ready tied high, then halt.
        put(32'h00, enc_i(8, 0, 1, 16'h0005), 32'h5, 4);
        put(32'h04, enc_i(8, 0, 2, 16'hFFFD), 32'hFFFF_FFFD, 4);
        put(32'h08, enc_r(1, 2, 3, 0, 'h20), 32'h2, 4);
        put(32'h0C, HALT, 32'h2, 3);
        release_reset();
        run_halt(100);
        // T6: halted core issues no further fetches.
        seen = 0;
        repeat (6) begin @(negedge clk); if (imem_req) seen++; end
        chk("halt_no_fetch", 32'(seen), 32'h0);
        chk("halt_held", 32'(halted), 32'h1);

        // T2: store then load with 3 dmem wait states; restart after halt.
        start_reset();
        put(32'h00, enc_i(8, 0, 1, 16'h0005), 32'h5, 4);
        put(32'h04, enc_i(8, 0, 2, 16'h0009), 32'h9, 4);
        put(32'h08, enc_i('h2B, 0, 1, 16'h0008), 32'h5, 7);
        put(32'h0C, enc_i('h23, 0, 4, 16'h0008), 32'h5, 8);
        put(32'h10, enc_r(4, 4, 6, 0, 'h20), 32'hA, 4);
        put(32'h14, HALT, 32'hA, 3);
        dq.push_back('{addr: 32'h8, we: 1'b1, wdata: 32'h5});
        dq.push_back('{addr: 32'h8, we: 1'b0, wdata: 32'h0});
        dwait = 3;
        release_reset();
        #1;
        chk("restart_req", 32'(imem_req), 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_halted", 32'(halted), 32'h0);
        run_halt(200);
        chk("dmem_drained", 32'(dq.size()), 32'h0);

        // T3a: beq r1,r1,-1 at 0x10 spins on its own address.
        start_reset();
        chk_fetch = 1;
        put(32'h00, enc_i(8, 0, 1, 16'h0005), 32'h5, 4);
        put(32'h04, enc_j(2, 4), 32'h10, 3);
        put(32'h10, enc_i(4, 1, 1, 16'hFFFF), 32'h10, 3);
        exp_q.push_back('{res: 32'h10, gap: 3});
        exp_q.push_back('{res: 32'h10, gap: 3});
        fq = '{32'h0, 32'h4, 32'h10, 32'h10, 32'h10, 32'h10};
        release_reset();
        run_ret(5, 100);
        chk("fetch_drained", 32'(fq.size()), 32'h0);

        // T3b: bne not taken, j, jal with link into r31.
        start_reset();
        chk_fetch = 1;
        put(32'h00, enc_i(8, 0, 1, 16'h0005), 32'h5, 4);
        put(32'h04, enc_j(2, 4), 32'h10, 3);
        put(32'h10, enc_i(5, 1, 1, 16'hFFFF), 32'h14, 3);
        put(32'h14, enc_j(2, 8), 32'h20, 3);
        put(32'h20, enc_j(3, 'h40), 32'h100, 3);
        put(32'h100, enc_r(31, 0, 7, 0, 'h20), 32'h24, 4);
        put(32'h104, HALT, 32'h24, 3);
        fq = '{32'h0, 32'h4, 32'h10, 32'h14, 32'h20, 32'h100, 32'h104};
        release_reset();
        run_halt(200);
        chk("fetch_drained", 32'(fq.size()), 32'h0);

        // T4: r0 semantics and the rest of the ALU, with one imem wait state.
        start_reset();
        iwait = 1;
        put(32'h00, enc_i(8, 0, 0, 16'h0007), 32'h7, 5);
        put(32'h04, enc_r(0, 0, 5, 0, 'h20), 32'h0, 5);
        put(32'h08, enc_i(8, 0, 8, 16'hFFFF), 32'hFFFF_FFFF, 5);
        put(32'h0C, enc_i(8, 0, 9, 16'h0001), 32'h1, 5);
        put(32'h10, enc_r(8, 9, 10, 0, 'h2A), 32'h1, 5);
        put(32'h14, enc_r(0, 0, 11, 0, 'h27), 32'hFFFF_FFFF, 5);
        put(32'h18, enc_i('h0F, 0, 12, 16'h1234), 32'h1234_0000, 5);
        put(32'h1C, enc_i('h0D, 12, 12, 16'h8001), 32'h1234_8001, 5);
        put(32'h20, enc_i('h0C, 12, 13, 16'hFFFF), 32'h0000_8001, 5);
        put(32'h24, enc_r(0, 9, 14, 4, 'h00), 32'h10, 5);
        put(32'h28, enc_r(0, 8, 15, 28, 'h02), 32'hF, 5);
        put(32'h2C, enc_r(9, 8, 16, 0, 'h22), 32'h2, 5);
        put(32'h30, enc_i('h20, 0, 19, 16'h0000), 32'h2, 0);
        put(32'h34, enc_r(9, 8, 17, 0, 'h2A), 32'h0, 5);
        put(32'h38, enc_i(8, 0, 18, 16'h0080), 32'h80, 5);
        put(32'h3C, enc_r(18, 0, 0, 0, 'h08), 32'h80, 4);
        put(32'h80, HALT, 32'h80, 4);
        release_reset();
        run_halt(300);

        // T5: reset asserted while a store is waiting in MEM.
        start_reset();
        put(32'h00, enc_i(8, 0, 1, 16'h0005), 32'h5, 4);
        imem[1] = enc_i('h2B, 0, 1, 16'h0008);
        dq.push_back('{addr: 32'h8, we: 1'b1, wdata: 32'h5});
        dwait = 50;
        release_reset();
        for (int k = 0; k < 30; k++) begin @(negedge clk); #1; if (dmem_req) break; end
        chk("t5_req_seen", 32'(dmem_req), 32'h1);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        chk("t5_dmem_req", 32'(dmem_req), 32'h0);
        chk("t5_imem_addr", imem_addr, 32'h0);
        chk("t5_result", result, 32'h0);
        chk("t5_dmem_untouched", dmem[2], 32'h0);
        start_reset();
        put(32'h00, enc_r(1, 0, 2, 0, 'h20), 32'h0, 4);
        put(32'h04, HALT, 32'h0, 3);
        release_reset();
        run_halt(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
